// File: rtl/oc8051_debug_xrom_mp_if.sv
// Bus bundle for oc8051_debug_xrom_mp: load channel, word read port and PC lookup ports.
// master = debug controller side, slave = ROM side.
interface oc8051_debug_xrom_mp_if #(
  parameter int unsigned NPORT  = 2,
  parameter int unsigned NBYTES = 3
);
  logic                        load_start;
  logic                        load_valid;
  logic [31:0]                 load_word;
  logic                        load_ready;
  logic                        load_done;
  logic                        rd_en;
  logic [15:0]                 rd_addr;
  logic [31:0]                 rd_data;
  logic                        rd_valid;
  logic [NPORT-1:0]            pc_req;
  logic [NPORT*16-1:0]         pc;
  logic [NPORT-1:0]            op_ack;
  logic [NPORT-1:0]            op_valid;
  logic [NPORT*NBYTES*8-1:0]   op_out;
  logic [NPORT*16-1:0]         oor_cnt;

  modport master (
    output load_start, load_valid, load_word, rd_en, rd_addr, pc_req, pc,
    input  load_ready, load_done, rd_data, rd_valid, op_ack, op_valid, op_out, oor_cnt
  );

  modport slave (
    input  load_start, load_valid, load_word, rd_en, rd_addr, pc_req, pc,
    output load_ready, load_done, rd_data, rd_valid, op_ack, op_valid, op_out, oor_cnt
  );
endinterface

// File: rtl/oc8051_debug_xrom_mp.sv
// Run-time-loadable multi-port debug instruction ROM with registered 1-cycle lookups.
// Optional per-port out-of-range counters: define OC8051_XROM_STATS_EN.
module oc8051_debug_xrom_mp #(
  parameter int unsigned NPORT   = 2,
  parameter int unsigned ROMSIZE = 182,
  parameter int unsigned NBYTES  = 3,
  parameter int unsigned WINDOW  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  oc8051_debug_xrom_mp_if.slave  bus
);

  localparam int unsigned IW = (ROMSIZE > 1) ? $clog2(ROMSIZE) : 1;
  localparam int unsigned CW = 17;
  localparam int unsigned RW = 18;
  localparam logic [RW-1:0] ROM_END = RW'(ROMSIZE);

  typedef enum logic [1:0] {EMPTY, LOAD, READY} state_t;

  state_t                    state;
  logic [CW-1:0]             cnt;
  logic [7:0]                mem [ROMSIZE];
  logic                      load_ready;
  logic                      load_done;
  logic [NPORT-1:0]          op_ack;
  logic [NPORT-1:0]          op_valid;
  logic [NPORT*NBYTES*8-1:0] op_out;
  logic                      rd_valid;
  logic [31:0]               rd_data;
  logic                      wr_en_c;
  logic [RW-1:0]             pc_ext_c [NPORT];
  logic [NPORT-1:0]          in_range_c;
  logic [RW-1:0]             rd_base_c;

  // Out-of-range addresses read as zero; 18-bit compare so nothing wraps.
  function automatic logic [7:0] rom_byte(input logic [RW-1:0] addr);
    rom_byte = (addr < ROM_END) ? mem[IW'(addr)] : 8'h00;
  endfunction

  assign wr_en_c   = (state == LOAD) && bus.load_valid && !bus.load_start;
  assign rd_base_c = {bus.rd_addr, 2'b00};

  always_comb begin
    for (int i = 0; i < NPORT; i++) begin
      pc_ext_c[i]   = RW'(bus.pc[16*i +: 16]);
      in_range_c[i] = (pc_ext_c[i] + RW'(WINDOW - 1)) < ROM_END;
    end
  end

  // Byte store: deliberately not reset; bytes past ROMSIZE in the last word are dropped.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      for (int j = 0; j < 4; j++) begin
        if ((RW'(cnt) + RW'(j)) < ROM_END)
          mem[IW'(RW'(cnt) + RW'(j))] <= bus.load_word[8*j +: 8];
      end
    end
  end

  // Load FSM; load_start restarts from any state and wins over load_valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= EMPTY;
      cnt        <= '0;
      load_ready <= 1'b0;
      load_done  <= 1'b0;
    end else if (bus.load_start) begin
      state      <= LOAD;
      cnt        <= '0;
      load_ready <= 1'b1;
      load_done  <= 1'b0;
    end else if (wr_en_c) begin
      cnt <= cnt + CW'(4);
      if ((RW'(cnt) + RW'(4)) >= ROM_END) begin
        state      <= READY;
        load_ready <= 1'b0;
        load_done  <= 1'b1;
      end
    end
  end

  // Lookup and word-read pipelines; results hold until the next request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_ack   <= '0;
      op_valid <= '0;
      op_out   <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      op_ack   <= bus.pc_req;
      rd_valid <= bus.rd_en;
      for (int i = 0; i < NPORT; i++) begin
        if (bus.pc_req[i]) begin
          op_valid[i] <= (state == READY) && in_range_c[i];
          for (int k = 0; k < NBYTES; k++)
            op_out[8*(NBYTES*i+k) +: 8] <= (state == READY) ?
                                           rom_byte(pc_ext_c[i] + RW'(k)) : 8'h00;
        end
      end
      if (bus.rd_en) begin
        for (int j = 0; j < 4; j++)
          rd_data[8*j +: 8] <= (state == EMPTY) ? 8'h00 : rom_byte(rd_base_c + RW'(j));
      end
    end
  end

`ifdef OC8051_XROM_STATS_EN
  logic [NPORT*16-1:0] oor_cnt;

  // Saturating count of READY lookups whose window falls off the end of the store.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      oor_cnt <= '0;
    end else if (bus.load_start) begin
      oor_cnt <= '0;
    end else begin
      for (int i = 0; i < NPORT; i++) begin
        if ((state == READY) && bus.pc_req[i] && !in_range_c[i] &&
            (oor_cnt[16*i +: 16] != 16'hFFFF))
          oor_cnt[16*i +: 16] <= oor_cnt[16*i +: 16] + 16'd1;
      end
    end
  end

  assign bus.oor_cnt = oor_cnt;
`else
  assign bus.oor_cnt = '0;
`endif

  assign bus.load_ready = load_ready;
  assign bus.load_done  = load_done;
  assign bus.op_ack     = op_ack;
  assign bus.op_valid   = op_valid;
  assign bus.op_out     = op_out;
  assign bus.rd_valid   = rd_valid;
  assign bus.rd_data    = rd_data;

endmodule

// File: tb/tb_oc8051_debug_xrom_mp.sv
// Randomized self-checking bench for oc8051_debug_xrom_mp against a per-cycle behavioural model.
module tb_oc8051_debug_xrom_mp;
  localparam int NPORT   = 2;
  localparam int ROMSIZE = 182;
  localparam int NBYTES  = 3;
  localparam int WINDOW  = 4;
`ifdef OC8051_XROM_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef enum int {M_EMPTY, M_LOAD, M_READY} mstate_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  oc8051_debug_xrom_mp_if #(.NPORT(NPORT), .NBYTES(NBYTES)) bus ();

  oc8051_debug_xrom_mp #(
    .NPORT(NPORT), .ROMSIZE(ROMSIZE), .NBYTES(NBYTES), .WINDOW(WINDOW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  mstate_t    m_state;
  int         m_cnt;
  logic [7:0] m_mem   [ROMSIZE];
  bit         m_known [ROMSIZE];
  int         m_oor   [NPORT];
  bit         e_ack   [NPORT];
  bit         e_val   [NPORT];
  logic [7:0] e_op    [NPORT][NBYTES];
  bit         e_opk   [NPORT][NBYTES];
  bit         e_rdv;
  logic [7:0] e_rd    [4];
  bit         e_rdk   [4];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void peek(input int addr, output logic [7:0] b, output bit k);
    if (addr < ROMSIZE) begin
      b = m_mem[addr];
      k = m_known[addr];
    end else begin
      b = 8'h00;
      k = 1'b1;
    end
  endfunction

  task automatic reset_model();
    m_state = M_EMPTY;
    m_cnt   = 0;
    e_rdv   = 1'b0;
    for (int i = 0; i < NPORT; i++) begin
      m_oor[i] = 0;
      e_ack[i] = 1'b0;
      e_val[i] = 1'b0;
      for (int k = 0; k < NBYTES; k++) begin
        e_op[i][k]  = 8'h00;
        e_opk[i][k] = 1'b1;
      end
    end
    for (int j = 0; j < 4; j++) begin
      e_rd[j]  = 8'h00;
      e_rdk[j] = 1'b1;
    end
  endtask

  // Advance the model by one clock edge using the inputs currently on the bus.
  task automatic model_edge();
    mstate_t s = m_state;
    for (int i = 0; i < NPORT; i++) begin
      e_ack[i] = bus.pc_req[i];
      if (bus.pc_req[i]) begin
        int pcv = int'(bus.pc[16*i +: 16]);
        if (s == M_READY) begin
          for (int k = 0; k < NBYTES; k++) peek(pcv + k, e_op[i][k], e_opk[i][k]);
          e_val[i] = (pcv + WINDOW - 1) < ROMSIZE;
          if (!e_val[i] && m_oor[i] < 65535) m_oor[i]++;
        end else begin
          e_val[i] = 1'b0;
          for (int k = 0; k < NBYTES; k++) begin
            e_op[i][k]  = 8'h00;
            e_opk[i][k] = 1'b1;
          end
        end
      end
    end
    e_rdv = bus.rd_en;
    if (bus.rd_en) begin
      int a = 4 * int'(bus.rd_addr);
      for (int j = 0; j < 4; j++) begin
        if (s == M_EMPTY) begin
          e_rd[j]  = 8'h00;
          e_rdk[j] = 1'b1;
        end else begin
          peek(a + j, e_rd[j], e_rdk[j]);
        end
      end
    end
    if (bus.load_start) begin
      m_state = M_LOAD;
      m_cnt   = 0;
      for (int i = 0; i < NPORT; i++) m_oor[i] = 0;
    end else if (s == M_LOAD && bus.load_valid) begin
      for (int j = 0; j < 4; j++) begin
        if (m_cnt + j < ROMSIZE) begin
          m_mem[m_cnt + j]   = bus.load_word[8*j +: 8];
          m_known[m_cnt + j] = 1'b1;
        end
      end
      m_cnt += 4;
      if (m_cnt >= ROMSIZE) m_state = M_READY;
    end
  endtask

  task automatic compare_all();
    check("load_ready", 64'(bus.load_ready), 64'(m_state == M_LOAD));
    check("load_done",  64'(bus.load_done),  64'(m_state == M_READY));
    check("rd_valid",   64'(bus.rd_valid),   64'(e_rdv));
    for (int j = 0; j < 4; j++)
      if (e_rdk[j]) check($sformatf("rd_b%0d", j), 64'(bus.rd_data[8*j +: 8]), 64'(e_rd[j]));
    for (int i = 0; i < NPORT; i++) begin
      check($sformatf("ack_p%0d", i), 64'(bus.op_ack[i]),   64'(e_ack[i]));
      check($sformatf("val_p%0d", i), 64'(bus.op_valid[i]), 64'(e_val[i]));
      check($sformatf("oor_p%0d", i), 64'(bus.oor_cnt[16*i +: 16]),
            STATS ? 64'(m_oor[i]) : 64'd0);
      for (int k = 0; k < NBYTES; k++)
        if (e_opk[i][k])
          check($sformatf("op_p%0d_b%0d", i, k),
                64'(bus.op_out[8*(NBYTES*i+k) +: 8]), 64'(e_op[i][k]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_word  = '0;
    bus.rd_en      = 1'b0;
    bus.rd_addr    = '0;
    bus.pc_req     = '0;
    bus.pc         = '0;
  endtask

  function automatic logic [15:0] rand_pc();
    case ($urandom_range(0, 3))
      0:       rand_pc = 16'(ROMSIZE - 8 + $urandom_range(0, 15));
      1:       rand_pc = 16'(16'hFFF0 + $urandom_range(0, 15));
      default: rand_pc = 16'($urandom_range(0, ROMSIZE - 1));
    endcase
  endfunction

  initial begin
    for (int a = 0; a < ROMSIZE; a++) m_known[a] = 1'b0;
    idle_inputs();
    reset_model();
    rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    compare_all();
    check("reset_op_out", 64'(bus.op_out), 64'd0);
    rst = 1'b1;

    // Lookup in EMPTY, together with the load_start
    bus.load_start = 1'b1;
    bus.pc_req     = 2'b11;
    bus.pc         = {16'h0005, 16'h0001};
    step();
    check("empty_ack", 64'(bus.op_ack), 64'(2'b11));
    check("empty_val", 64'(bus.op_valid), 64'd0);
    idle_inputs();

    // Directed load: byte n = n[7:0]
    for (int n = 0; n < 46; n++) begin
      bus.load_valid = 1'b1;
      bus.load_word  = {8'(4*n+3), 8'(4*n+2), 8'(4*n+1), 8'(4*n)};
      bus.pc_req     = (n == 20) ? 2'b01 : (n == 45) ? 2'b10 : 2'b00;
      bus.pc         = {16'h0010, 16'h0010};
      step();
      if (n == 44) check("load_done_early", 64'(bus.load_done), 64'd0);
    end
    check("load_done_46", 64'(bus.load_done), 64'd1);
    check("lastword_val", 64'(bus.op_valid[1]), 64'd0);
    check("lastword_op",  64'(bus.op_out[47:24]), 64'd0);
    bus.load_word = 32'hDEADBEEF;
    bus.pc_req    = '0;
    step();
    idle_inputs();

    bus.pc_req = 2'b11;
    bus.pc     = {16'h00B2, 16'h0010};
    step();
    check("dir_ack",  64'(bus.op_ack),   64'(2'b11));
    check("dir_val",  64'(bus.op_valid), 64'(2'b11));
    check("dir_op",   64'(bus.op_out),   64'hB4B3B2_121110);
    bus.pc_req = 2'b10;
    bus.pc     = {16'h00B4, 16'h0000};
    step();
    check("edge_op1",  64'(bus.op_out[47:24]), 64'h00B5B4);
    check("edge_val1", 64'(bus.op_valid[1]), 64'd0);
    bus.pc_req = 2'b01;
    bus.pc     = {16'h0000, 16'hFFFF};
    step();
    check("wrap_op0",  64'(bus.op_out[23:0]), 64'd0);
    check("wrap_val0", 64'(bus.op_valid[0]), 64'd0);
`ifdef OC8051_XROM_STATS_EN
    check("oor_both", 64'(bus.oor_cnt), 64'h0001_0001);
`endif
    idle_inputs();
    bus.rd_en   = 1'b1;
    bus.rd_addr = 16'h002D;
    step();
    check("rd_2d", 64'(bus.rd_data), 64'h0000B5B4);
    bus.rd_addr = 16'h0030;
    step();
    check("rd_30", 64'(bus.rd_data), 64'd0);
    idle_inputs();

    // Reload from READY, then reset part-way through
    bus.load_start = 1'b1;
    step();
    check("reload_done", 64'(bus.load_done), 64'd0);
    check("reload_oor",  64'(bus.oor_cnt), 64'd0);
    idle_inputs();
    for (int n = 0; n < 10; n++) begin
      bus.load_valid = 1'b1;
      bus.load_word  = $urandom;
      bus.pc_req     = 2'($urandom);
      bus.pc         = {rand_pc(), rand_pc()};
      bus.rd_en      = 1'($urandom);
      bus.rd_addr    = 16'($urandom_range(0, 48));
      step();
    end
    idle_inputs();
    rst = 1'b0;
    reset_model();
    #1;
    compare_all();
    check("rst_op_out", 64'(bus.op_out), 64'd0);
    @(posedge clk);
    #1;
    compare_all();
    rst = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_word  = 32'h12345678;
    step();
    check("ignored_ready", 64'(bus.load_ready), 64'd0);
    idle_inputs();

    // Randomized traffic including reloads
    bus.load_start = 1'b1;
    step();
    idle_inputs();
    for (int c = 0; c < 1500; c++) begin
      bus.load_start = ($urandom_range(0, 119) == 0);
      bus.load_valid = 1'($urandom);
      bus.load_word  = $urandom;
      bus.pc_req     = 2'($urandom);
      bus.pc         = {rand_pc(), rand_pc()};
      bus.rd_en      = 1'($urandom);
      bus.rd_addr    = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 48));
      step();
    end
    idle_inputs();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
